// File: rtl/if_id_latch_if.sv
// Fetch-to-decode boundary bundle for the IF/ID pipeline register.
// The perf counter outputs exist only when IFID_PERF_CNT_EN is defined.
interface if_id_latch_if;
    logic [15:0] instr_in;
    logic [15:0] next_pc_basic_in;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic [15:0] instr_out;
    logic [15:0] next_pc_basic_out;
    logic        valid_out;
    logic        halt_fetch;
    logic        err;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] bubble_cycles;
`endif

    // master drives fetch/control inputs and observes the stage outputs
    modport master (
        output instr_in, next_pc_basic_in, valid_in, stall, flush,
        input  instr_out, next_pc_basic_out, valid_out, halt_fetch, err
`ifdef IFID_PERF_CNT_EN
        , input stall_cycles, bubble_cycles
`endif
    );

    modport slave (
        input  instr_in, next_pc_basic_in, valid_in, stall, flush,
        output instr_out, next_pc_basic_out, valid_out, halt_fetch, err
`ifdef IFID_PERF_CNT_EN
        , output stall_cycles, bubble_cycles
`endif
    );
endinterface

// File: rtl/if_id_latch.sv
// IF/ID pipeline register with stall, flush, valid tracking and HALT detection.
// Optional macro IFID_PERF_CNT_EN adds stall/bubble cycle counters.
module if_id_latch #(
    parameter logic [15:0] NOP_INSTR   = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic          clk,
    input  logic          rst,
    if_id_latch_if.slave  bus
);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;
    logic        err_q;

    logic is_halt;
    assign is_halt = bus.valid_in && (bus.instr_in[15:11] == HALT_OPCODE);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        if (bus.flush) begin
            // a HALT squashed by a redirect was on the wrong path
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = ST_RUN;
            halt_d  = 1'b0;
        end else if (!bus.stall) begin
            if (state_q == ST_HALTED) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                instr_d = bus.instr_in;
                pc_d    = bus.next_pc_basic_in;
                valid_d = bus.valid_in;
                if (is_halt) begin
                    state_d = ST_HALTED;
                    halt_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            instr_q <= NOP_INSTR;
            pc_q    <= 16'h0000;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
            err_q   <= 1'b0;
        end
    end

    assign bus.instr_out         = instr_q;
    assign bus.next_pc_basic_out = pc_q;
    assign bus.valid_out         = valid_q;
    assign bus.halt_fetch        = halt_q;
    assign bus.err               = err_q;

`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        bubble_inc;

    // every edge that leaves valid_out low: flush, HALTED load or invalid fetch
    assign bubble_inc = bus.flush ||
                        (!bus.stall && ((state_q == ST_HALTED) || !bus.valid_in));

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.stall && !bus.flush) stall_cnt_d = stall_cnt_q + 16'd1;
        if (bubble_inc) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= 16'h0000;
            bubble_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall_cycles  = stall_cnt_q;
    assign bus.bubble_cycles = bubble_cnt_q;
`endif

endmodule

// File: doc/if_id_latch.md
Name: if_id_latch

Overview:
- Pipeline register between the fetch stage and the decode stage.
- Captures the fetched instruction and the PC+2 value each cycle.
- Supports stall (hold) and flush (bubble insertion), and carries a valid bit.
- Owns the halt-detection state machine, which freezes fetch once a HALT instruction has been latched.

Parameters:
- NOP_INSTR, 16'h0800, encoding injected on reset, flush and post-halt bubbles.
- HALT_OPCODE, 5'b00000, value of instr[15:11] that identifies HALT.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- instr_in  input  16  instruction from fetch.
- next_pc_basic_in  input  16  PC+2 from fetch.
- valid_in  input  1  fetch output is a real instruction.
- stall  input  1  decode/hazard unit requests hold.
- flush  input  1  control redirect; squash the latched instruction.
- instr_out  output  16  instruction presented to decode.
- next_pc_basic_out  output  16  PC+2 presented to decode.
- valid_out  output  1  instr_out is a real instruction.
- halt_fetch  output  1  registered; fetch must hold its PC while high.
- err  output  1  stage error flag.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high.
  - All outputs are registered.
- Reset values (next edge with rst=1):
  - instr_out=NOP_INSTR, next_pc_basic_out=16'h0000, valid_out=0.
  - State=RUN, halt_fetch=0, err=0.
- Update priority per edge: rst > flush > stall > load.
- Flush:
  - instr_out<=NOP_INSTR, valid_out<=0, next_pc_basic_out holds.
  - State<=RUN, halt_fetch<=0; a squashed HALT was speculative.
  - Flush overrides a simultaneous stall.
- Stall (flush=0): all registers and state hold, including halt_fetch.
- Load (no rst, flush or stall):
  - In RUN: instr_out<=instr_in, next_pc_basic_out<=next_pc_basic_in, valid_out<=valid_in.
  - In HALTED: instr_out<=NOP_INSTR, valid_out<=0, next_pc_basic_out holds. Repeated HALT refetches are discarded.
- Latency: one cycle from fetch output to decode input.
- State machine:
  - RUN -> HALTED on a load edge where valid_in=1 and instr_in[15:11]==HALT_OPCODE. On that same edge the HALT itself is latched with valid_out=1 and halt_fetch<=1.
  - HALTED -> RUN only on flush.
  - rst forces RUN from any state.
  - A HALT with valid_in=0 does not trigger the transition.
- halt_fetch is high exactly while state=HALTED.
- err is a registered 0. It is reserved for parity with the other stages and is never asserted in this revision.
- Widths: all data paths are 16-bit. No arithmetic is performed; PC values pass through unmodified, including 16'hFFFE/16'h0000 wrap values from fetch.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- When defined, two extra output ports are added:
  - stall_cycles[15:0]: counts edges with stall=1 and flush=0.
  - bubble_cycles[15:0]: counts edges that load or inject valid_out=0 (flush, HALTED load, or valid_in=0 load).
- Both counters reset to 0 on rst and wrap at 16'hFFFF->16'h0000.
- When undefined, neither port nor counter logic exists; behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 one cycle with instr_in=16'h1234 -> instr_out=16'h0800, valid_out=0, next_pc_basic_out=0, halt_fetch=0.
- Streaming: load instr_in=16'hC005/pc=16'h0002, then 16'hC106/16'h0004 on consecutive cycles with valid_in=1 -> outputs follow one cycle later; valid_out=1 both cycles.
- Stall hold: latch 16'hC005, then stall=1 for 3 cycles while instr_in changes -> instr_out stays 16'hC005 and valid_out stays 1. Release -> new value appears next edge.
- Flush priority: stall=1 and flush=1 on the same edge with 16'hC005 latched -> instr_out=16'h0800, valid_out=0.
- Halt: load 16'h0000 with valid_in=1 -> instr_out=16'h0000, valid_out=1, halt_fetch=1. Next loads of 16'h0000 -> instr_out=16'h0800, valid_out=0, halt_fetch stays 1. Flush -> halt_fetch=0, loads resume.
- Perf counters (IFID_PERF_CNT_EN): 4 stall edges plus 2 flush edges -> stall_cycles=4, bubble_cycles=2. Preload stall_cycles to 16'hFFFF via stimulus, one more stall -> wraps to 0.
